// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scancode_decoder
//  Description : Decodes PS/2 set-2 scancodes (with E0/F0 prefixes), tracks
//                shift/caps modifiers, translates letters, digits and a few
//                control keys to ASCII and buffers them in a small
//                first-word-fall-through FIFO with a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_cpu,
    input  logic       reset,
    input  logic [7:0] scancode,
    input  logic       is_valid,
    input  logic       rd_en,
    output logic [7:0] ascii,
    output logic       empty,
    output logic       overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             shift;
    logic             shift_next;
    logic             caps;
    logic             caps_next;
    logic             push;

    logic [7:0]       xl_char;
    logic             xl_hit;
    logic             xl_letter;
    logic [7:0]       push_char;
    logic             is_shift_code;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             ovf_flag;
    logic             full;
    logic             pop;
    logic             push_ok;

    // Scancode to base character; letters come out lowercase, 0x00 means no mapping.
    always_comb begin
        xl_char = 8'h00;
        case (scancode)
            8'h1C: xl_char = 8'h61;  8'h32: xl_char = 8'h62;  8'h21: xl_char = 8'h63;
            8'h23: xl_char = 8'h64;  8'h24: xl_char = 8'h65;  8'h2B: xl_char = 8'h66;
            8'h34: xl_char = 8'h67;  8'h33: xl_char = 8'h68;  8'h43: xl_char = 8'h69;
            8'h3B: xl_char = 8'h6A;  8'h42: xl_char = 8'h6B;  8'h4B: xl_char = 8'h6C;
            8'h3A: xl_char = 8'h6D;  8'h31: xl_char = 8'h6E;  8'h44: xl_char = 8'h6F;
            8'h4D: xl_char = 8'h70;  8'h15: xl_char = 8'h71;  8'h2D: xl_char = 8'h72;
            8'h1B: xl_char = 8'h73;  8'h2C: xl_char = 8'h74;  8'h3C: xl_char = 8'h75;
            8'h2A: xl_char = 8'h76;  8'h1D: xl_char = 8'h77;  8'h22: xl_char = 8'h78;
            8'h35: xl_char = 8'h79;  8'h1A: xl_char = 8'h7A;
            8'h45: xl_char = 8'h30;  8'h16: xl_char = 8'h31;  8'h1E: xl_char = 8'h32;
            8'h26: xl_char = 8'h33;  8'h25: xl_char = 8'h34;  8'h2E: xl_char = 8'h35;
            8'h36: xl_char = 8'h36;  8'h3D: xl_char = 8'h37;  8'h3E: xl_char = 8'h38;
            8'h46: xl_char = 8'h39;
            8'h29: xl_char = 8'h20;  8'h5A: xl_char = 8'h0D;  8'h66: xl_char = 8'h08;
            default: xl_char = 8'h00;
        endcase
    end

    // Case selection uses the modifier state held before this strobe.
    assign xl_hit        = (xl_char != 8'h00);
    assign xl_letter     = (xl_char >= 8'h61);
    assign push_char     = (xl_letter && (shift ^ caps)) ? (xl_char & 8'hDF) : xl_char;
    assign is_shift_code = (scancode == SC_LSHIFT) || (scancode == SC_RSHIFT);

    // Prefix state, modifier flags and ASCII push request, all gated by is_valid.
    always_comb begin
        state_next = state;
        shift_next = shift;
        caps_next  = caps;
        push       = 1'b0;
        if (is_valid) begin
            case (state)
                IDLE: begin
                    if (scancode == SC_BREAK) begin
                        state_next = BRK;
                    end else if (scancode == SC_EXT) begin
                        state_next = EXT;
                    end else if (is_shift_code) begin
                        shift_next = 1'b1;
                    end else if (scancode == SC_CAPS) begin
                        caps_next = ~caps;
                    end else begin
                        push = xl_hit;
                    end
                end
                BRK: begin
                    state_next = IDLE;
                    if (is_shift_code) begin
                        shift_next = 1'b0;
                    end
                end
                EXT: begin
                    state_next = (scancode == SC_BREAK) ? EXT_BRK : IDLE;
                end
                EXT_BRK: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Prefix state and modifier registers.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state <= IDLE;
            shift <= 1'b0;
            caps  <= 1'b0;
        end else begin
            state <= state_next;
            shift <= shift_next;
            caps  <= caps_next;
        end
    end

    // A push into a full FIFO still succeeds when a pop frees the slot in the same cycle.
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop     = rd_en && !empty;
    assign push_ok = push && (!full || pop);

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf_flag <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push && full && !pop) begin
                ovf_flag <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because ascii is masked while empty.
    always_ff @(posedge clk_cpu) begin
        if (!reset && push_ok) begin
            mem[wr_ptr] <= push_char;
        end
    end

    assign ascii    = empty ? 8'h00 : mem[rd_ptr];
    assign overflow = ovf_flag;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_scancode_decoder
//  Description : Directed vector table plus randomized scancode traffic
//                compared against a queue-based keyboard model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scancode_decoder;

    localparam int FIFO_DEPTH = 4;
    localparam int N_RANDOM   = 1500;

    localparam logic [7:0] LETTER_CODES [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIGIT_CODES [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    logic       clk_cpu = 1'b0;
    logic       reset;
    logic [7:0] scancode;
    logic       is_valid;
    logic       rd_en;
    logic [7:0] ascii;
    logic       empty;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    ps2_scancode_decoder #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_cpu  (clk_cpu),
        .reset    (reset),
        .scancode (scancode),
        .is_valid (is_valid),
        .rd_en    (rd_en),
        .ascii    (ascii),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 clk_cpu = ~clk_cpu;

    // Keyboard model: pending prefixes as flags, FIFO as a queue.
    logic [7:0] mq [$];
    logic       m_shift, m_caps, m_brk, m_ext, m_ovf;

    function automatic int lookup(input logic [7:0] c, input logic upper);
        for (int i = 0; i < 26; i++)
            if (LETTER_CODES[i] == c) return upper ? (65 + i) : (97 + i);
        for (int i = 0; i < 10; i++)
            if (DIGIT_CODES[i] == c) return 48 + i;
        if (c == 8'h29) return 32;
        if (c == 8'h5A) return 13;
        if (c == 8'h66) return 8;
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic v, input logic [7:0] c, input logic rd);
        int   ch;
        logic do_pop;
        if (r) begin
            mq.delete();
            m_shift = 1'b0; m_caps = 1'b0; m_brk = 1'b0; m_ext = 1'b0; m_ovf = 1'b0;
            return;
        end
        do_pop = rd && (mq.size() > 0);
        ch = -1;
        if (v) begin
            if (c == 8'hF0 && !m_brk) begin
                m_brk = 1'b1;
            end else if (c == 8'hE0 && !m_brk && !m_ext) begin
                m_ext = 1'b1;
            end else begin
                if (!m_ext && !m_brk) begin
                    if (c == 8'h12 || c == 8'h59) m_shift = 1'b1;
                    else if (c == 8'h58)          m_caps = ~m_caps;
                    else                          ch = lookup(c, m_shift ^ m_caps);
                end else if (!m_ext && m_brk) begin
                    if (c == 8'h12 || c == 8'h59) m_shift = 1'b0;
                end
                m_brk = 1'b0;
                m_ext = 1'b0;
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (ch >= 0) begin
            if (mq.size() < FIFO_DEPTH) mq.push_back(ch[7:0]);
            else                        m_ovf = 1'b1;
        end
    endtask

    task automatic check(input string what, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s #%0d: got 0x%02h, expected 0x%02h", what, idx, act, exp);
    endtask

    // One clock: inputs change on the falling edge, outputs are sampled 1 ns after the rising edge.
    task automatic cycle(input logic r, input logic v, input logic [7:0] c, input logic rd);
        @(negedge clk_cpu);
        reset = r; is_valid = v; scancode = c; rd_en = rd;
        @(posedge clk_cpu);
        model_step(r, v, c, rd);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] code;
        logic       rd;
        logic [7:0] exp_ascii;
        logic       exp_empty;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic r, input logic v, input logic [7:0] c, input logic rd,
                       input logic [7:0] ea, input logic ee, input logic eo);
        vec_t t;
        t.rst = r; t.v = v; t.code = c; t.rd = rd;
        t.exp_ascii = ea; t.exp_empty = ee; t.exp_ovf = eo;
        vecs.push_back(t);
    endtask

    initial begin
        reset = 1'b1; is_valid = 1'b0; scancode = 8'h00; rd_en = 1'b0;
        model_step(1'b1, 1'b0, 8'h00, 1'b0);

        // reset state
        add(1, 0, 8'h00, 0, 8'h00, 1, 0);
        // single make, then pop
        add(0, 1, 8'h1C, 0, 8'h61, 0, 0);
        add(0, 0, 8'h00, 1, 8'h00, 1, 0);
        // shift make/break around 'a'
        add(0, 1, 8'h12, 0, 8'h00, 1, 0);
        add(0, 1, 8'h1C, 0, 8'h41, 0, 0);
        add(0, 1, 8'hF0, 0, 8'h41, 0, 0);
        add(0, 1, 8'h12, 0, 8'h41, 0, 0);
        add(0, 1, 8'h1C, 0, 8'h41, 0, 0);
        add(0, 0, 8'h00, 1, 8'h61, 0, 0);
        add(0, 0, 8'h00, 1, 8'h00, 1, 0);
        // caps toggle, caps break ignored, shift XOR caps
        add(0, 1, 8'h58, 0, 8'h00, 1, 0);
        add(0, 1, 8'hF0, 0, 8'h00, 1, 0);
        add(0, 1, 8'h58, 0, 8'h00, 1, 0);
        add(0, 1, 8'h32, 0, 8'h42, 0, 0);
        add(0, 1, 8'h12, 0, 8'h42, 0, 0);
        add(0, 1, 8'h32, 0, 8'h42, 0, 0);
        add(0, 0, 8'h00, 1, 8'h62, 0, 0);
        add(0, 0, 8'h00, 1, 8'h00, 1, 0);
        add(0, 1, 8'hF0, 0, 8'h00, 1, 0);
        add(0, 1, 8'h12, 0, 8'h00, 1, 0);
        add(0, 1, 8'h1C, 0, 8'h41, 0, 0);
        add(0, 0, 8'h00, 1, 8'h00, 1, 0);
        // extended make and extended break are discarded
        add(0, 1, 8'hE0, 0, 8'h00, 1, 0);
        add(0, 1, 8'h1C, 0, 8'h00, 1, 0);
        add(0, 1, 8'hE0, 0, 8'h00, 1, 0);
        add(0, 1, 8'hF0, 0, 8'h00, 1, 0);
        add(0, 1, 8'h75, 0, 8'h00, 1, 0);
        add(0, 1, 8'h16, 0, 8'h31, 0, 0);
        add(0, 0, 8'h00, 1, 8'h00, 1, 0);
        // five spaces into a depth-4 FIFO, then drain
        for (int i = 0; i < 4; i++) add(0, 1, 8'h29, 0, 8'h20, 0, 0);
        add(0, 1, 8'h29, 0, 8'h20, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 1, 8'h20, 0, 1);
        add(0, 0, 8'h00, 1, 8'h00, 1, 1);
        add(1, 0, 8'h00, 0, 8'h00, 1, 0);
        // fifth push with a simultaneous pop: no overflow, occupancy stays 4
        for (int i = 0; i < 4; i++) add(0, 1, 8'h29, 0, 8'h20, 0, 0);
        add(0, 1, 8'h29, 1, 8'h20, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 1, 8'h20, 0, 0);
        add(0, 0, 8'h00, 1, 8'h00, 1, 0);
        // reset between break prefix and its code; strobe/rd in reset cycle ignored
        add(0, 1, 8'h58, 0, 8'h00, 1, 0);
        add(0, 1, 8'hF0, 0, 8'h00, 1, 0);
        add(1, 1, 8'h1C, 1, 8'h00, 1, 0);
        add(0, 1, 8'h1C, 0, 8'h61, 0, 0);
        add(0, 0, 8'h00, 1, 8'h00, 1, 0);

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].v, vecs[i].code, vecs[i].rd);
            check("vec ascii",    i, ascii,           vecs[i].exp_ascii);
            check("vec empty",    i, {7'd0, empty},    {7'd0, vecs[i].exp_empty});
            check("vec overflow", i, {7'd0, overflow}, {7'd0, vecs[i].exp_ovf});
        end

        // randomized traffic against the model
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int n = 0; n < N_RANDOM; n++) begin
            logic       r, v, rd;
            logic [7:0] c;
            int         sel;
            r   = ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 99) < 60);
            rd  = ($urandom_range(0, 99) < 30);
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: c = LETTER_CODES[$urandom_range(0, 25)];
                4:          c = DIGIT_CODES[$urandom_range(0, 9)];
                5:          c = ($urandom_range(0, 2) == 0) ? 8'h12 : (($urandom_range(0, 1) == 0) ? 8'h59 : 8'h58);
                6:          c = 8'hF0;
                7:          c = 8'hE0;
                8:          c = ($urandom_range(0, 2) == 0) ? 8'h29 : (($urandom_range(0, 1) == 0) ? 8'h5A : 8'h66);
                default:    c = 8'($urandom_range(0, 255));
            endcase
            cycle(r, v, c, rd);
            check("rnd ascii",    n, ascii,           (mq.size() > 0) ? mq[0] : 8'h00);
            check("rnd empty",    n, {7'd0, empty},    {7'd0, (mq.size() == 0)});
            check("rnd overflow", n, {7'd0, overflow}, {7'd0, m_ovf});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
